// File: rtl/fft_mag_stage_pkg.sv
// fft_mag_stage_pkg
// Constants shared by every channel of the FFT front end and the
// multi-channel peak detector downstream of it.
//   INDEX_WIDTH   : width of a bin index (xk) throughout the system
//   CHANNELS      : number of parallel channels
//   FFT_FRAME_LEN : bins per FFT frame
package fft_mag_stage_pkg;

   localparam int INDEX_WIDTH   = 11;
   localparam int CHANNELS      = 8;
   localparam int FFT_FRAME_LEN = 2048;

endpackage

// File: rtl/cplx_pwr_pipe.sv
// cplx_pwr_pipe
// Three-stage complex power pipeline: S1 registers the sample, S2 squares
// re and im, S3 sums them (or forces zero when the bin is masked).
// Sideband (valid, last, xk) travels in lockstep so the output beat is
// exactly three cycles behind the input beat.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   valid, last, keep   : input beat valid, frame end, in-band flag
//   xk                  : bin index to carry with the beat
//   sample              : {im, re}, two's complement
//   pwr_valid, pwr_last : output beat valid / frame end
//   pwr_xk              : bin index aligned with pwr_data
//   pwr_data            : re^2 + im^2 (unsigned), zero when masked
module cplx_pwr_pipe #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic                last,
   input  logic                keep,
   input  logic [IDX_W-1:0]    xk,
   input  logic [2*DATA_W-1:0] sample,
   output logic                pwr_valid,
   output logic                pwr_last,
   output logic [IDX_W-1:0]    pwr_xk,
   output logic [2*DATA_W-1:0] pwr_data
);

   logic signed [DATA_W-1:0]   re_reg, im_reg;
   logic signed [2*DATA_W-1:0] sq_re, sq_im;
   logic [2*DATA_W-1:0]        sq_re_reg, sq_im_reg, pwr_reg;
   logic [2:0]                 valid_reg, last_reg;
   logic                       keep1_reg, keep2_reg;
   logic [IDX_W-1:0]           xk1_reg, xk2_reg, xk3_reg;

   // Squares of a signed value are non-negative and at most 2^30, so the
   // 2*DATA_W result reinterprets safely as unsigned.
   assign sq_re = (2*DATA_W)'(re_reg) * (2*DATA_W)'(re_reg);
   assign sq_im = (2*DATA_W)'(im_reg) * (2*DATA_W)'(im_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         re_reg    <= '0;
         im_reg    <= '0;
         sq_re_reg <= '0;
         sq_im_reg <= '0;
         pwr_reg   <= '0;
         valid_reg <= '0;
         last_reg  <= '0;
         keep1_reg <= 1'b0;
         keep2_reg <= 1'b0;
         xk1_reg   <= '0;
         xk2_reg   <= '0;
         xk3_reg   <= '0;
      end else begin
         // S1
         re_reg    <= sample[DATA_W-1:0];
         im_reg    <= sample[2*DATA_W-1:DATA_W];
         keep1_reg <= keep;
         xk1_reg   <= xk;
         // S2
         sq_re_reg <= sq_re;
         sq_im_reg <= sq_im;
         keep2_reg <= keep1_reg;
         xk2_reg   <= xk1_reg;
         // S3: sum tops out at 2^31, which still fits the unsigned width
         pwr_reg   <= keep2_reg ? (sq_re_reg + sq_im_reg) : '0;
         xk3_reg   <= xk2_reg;
         // last is qualified by valid so an idle-cycle tlast never leaks out
         valid_reg <= {valid_reg[1:0], valid};
         last_reg  <= {last_reg[1:0], valid & last};
      end
   end

   assign pwr_valid = valid_reg[2];
   assign pwr_last  = last_reg[2];
   assign pwr_xk    = xk3_reg;
   assign pwr_data  = pwr_reg;

endmodule

// File: rtl/fft_mag_stage.sv
// fft_mag_stage
// Per-channel FFT front end: converts a stream of signed complex bins into
// an unsigned power stream for the peak detector, zeroes bins outside
// [lo_bin, hi_bin], and checks frame framing.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_axis_fft_*             : input bins {im, re}, tuser = reported bin index
//   lo_bin, hi_bin           : inclusive pass band (quasi-static)
//   err_clr                  : pulse clearing the sticky error flags
//   m_axis_mag_*             : power output, no backpressure
//   xk_out                   : bin index aligned with the output beat
//   len_err, idx_err         : sticky framing errors
//   frames_done              : completed-frame counter (wraps)
module fft_mag_stage
   import fft_mag_stage_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int IDX_W     = INDEX_WIDTH,
   parameter int FRAME_LEN = FFT_FRAME_LEN,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2*DATA_W-1:0] s_axis_fft_tdata,
   input  logic                s_axis_fft_tvalid,
   output logic                s_axis_fft_tready,
   input  logic                s_axis_fft_tlast,
   input  logic [IDX_W-1:0]    s_axis_fft_tuser,
   input  logic [IDX_W-1:0]    lo_bin,
   input  logic [IDX_W-1:0]    hi_bin,
   input  logic                err_clr,
   output logic [2*DATA_W-1:0] m_axis_mag_tdata,
   output logic                m_axis_mag_tvalid,
   output logic                m_axis_mag_tlast,
   output logic [IDX_W-1:0]    xk_out,
   output logic                len_err,
   output logic                idx_err,
   output logic [CNT_W-1:0]    frames_done
);

   localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FRAME_LEN - 1);

   logic             accept;
   logic             at_end;
   logic             in_band;
   logic             idx_set, len_set;
   logic [IDX_W-1:0] cnt_reg;
   logic [CNT_W-1:0] frames_reg;
   logic             len_err_reg, idx_err_reg;

   assign s_axis_fft_tready = ~rst;
   assign accept  = s_axis_fft_tvalid & ~rst;
   assign at_end  = (cnt_reg == LAST_BIN);
   // An inverted band (lo > hi) makes this false for every index.
   assign in_band = (s_axis_fft_tuser >= lo_bin) && (s_axis_fft_tuser <= hi_bin);

   assign idx_set = accept && (s_axis_fft_tuser != cnt_reg);
   // tlast on a bin other than the last is a short frame; reaching the last
   // bin without tlast is a long frame. Both reduce to a disagreement.
   assign len_set = accept && (s_axis_fft_tlast != at_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= '0;
         frames_reg  <= '0;
         len_err_reg <= 1'b0;
         idx_err_reg <= 1'b0;
      end else begin
         if (accept) begin
            // Restart on tlast, and also force a resync at the frame boundary
            // so a missing tlast cannot drag the count into the next frame.
            cnt_reg <= (s_axis_fft_tlast || at_end) ? '0 : cnt_reg + IDX_W'(1);
            if (s_axis_fft_tlast)
               frames_reg <= frames_reg + CNT_W'(1);
         end
         // A new error in the clearing cycle must not be lost.
         len_err_reg <= len_set | (len_err_reg & ~err_clr);
         idx_err_reg <= idx_set | (idx_err_reg & ~err_clr);
      end
   end

   cplx_pwr_pipe #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .valid     (accept),
      .last      (s_axis_fft_tlast),
      .keep      (in_band),
      .xk        (s_axis_fft_tuser),
      .sample    (s_axis_fft_tdata),
      .pwr_valid (m_axis_mag_tvalid),
      .pwr_last  (m_axis_mag_tlast),
      .pwr_xk    (xk_out),
      .pwr_data  (m_axis_mag_tdata)
   );

   assign len_err     = len_err_reg;
   assign idx_err     = idx_err_reg;
   assign frames_done = frames_reg;

endmodule
